fifo_bist: RTL and testbench
============================

FIFO_BIST -- requirements
Module: fifo_bist

Interface
REQ-001 The block SHALL have parameter WR_W, default 8, meaning write word width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter RATIO, default 2, meaning read word width divided by write word width, legal range 1..8.
REQ-003 The block SHALL have parameter LENGTH, default 256, meaning write words per test; it SHALL be a multiple of RATIO.
REQ-004 The block SHALL have parameter ERR_W, default 16, meaning error counter width.
REQ-005 The block SHALL have parameter TIMEOUT, default 4096, meaning the cycle limit for waiting on rd_valid.
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port start, input, 1 bit: pulse that begins a test.
REQ-009 The block SHALL have port mode, input, 2 bits: pattern select, 0 increment, 1 decrement, 2 LFSR, 3 walking-ones.
REQ-010 The block SHALL have port calib_done, input, 1 bit: DDR calibration complete.
REQ-011 The block SHALL have ports wr_data (output, WR_W), wr_en (output, 1) and wr_ready (input, 1): the FIFO write channel.
REQ-012 The block SHALL have ports rd_en (output, 1), rd_data (input, WR_W*RATIO) and rd_valid (input, 1): the FIFO read channel.
REQ-013 The block SHALL have status outputs busy (1), done (1), pass (1), timeout (1), err_count (ERR_W) and first_err_idx (clog2(LENGTH/RATIO)+1).

Function
REQ-014 States SHALL be IDLE, WAIT_CAL, WRITE, WAIT_RD, READ and DONE.
REQ-015 IDLE->WAIT_CAL on start=1; on this transition mode SHALL be latched, status cleared and both pattern generators reset.
REQ-016 WAIT_CAL->WRITE when calib_done=1; otherwise hold with no timeout.
REQ-017 WRITE SHALL drive wr_en=1 and wr_data=current write-pattern word; a word SHALL be accepted only on wr_en&&wr_ready, which advances the generator and the write count.
REQ-018 After the LENGTH-th accepted word, the next state SHALL be WAIT_RD, and wr_en SHALL be 0 from the following cycle.
REQ-019 WAIT_RD->READ on rd_valid=1.
REQ-020 READ SHALL drive rd_en=1 (also in WAIT_RD); a read word SHALL be consumed only on rd_en&&rd_valid, with rd_data sampled in that same cycle (first-word-fall-through).
REQ-021 Read word k SHALL be compared against expected write words k*RATIO..k*RATIO+RATIO-1, with word k*RATIO in the LSBs.
REQ-022 On a mismatch, err_count SHALL increment, saturating at all-ones; on the first mismatch, first_err_idx SHALL capture k.
REQ-023 After LENGTH/RATIO consumed words the next state SHALL be DONE; rd_en SHALL drop in DONE.
REQ-024 In WAIT_RD/READ a counter SHALL run while rd_valid=0 and clear on any consumed word; reaching TIMEOUT SHALL set timeout=1 and move to DONE.
REQ-025 DONE SHALL set done=1, with pass=1 iff err_count==0 and timeout==0; it SHALL return to IDLE on the next start, starting a new test in the same way as from IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE and DONE; start while busy SHALL be ignored.
REQ-027 Pattern for word i, increment: i mod 2^WR_W.
REQ-028 Pattern for word i, decrement: (2^WR_W-1-i) mod 2^WR_W.
REQ-029 Pattern for word i, walking-ones: 1<<(i mod WR_W).
REQ-030 Pattern for word i, LFSR: low WR_W bits of a 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 0xACE1ACE1, shift-left, feedback into bit 0, stepped once per word; word 0 SHALL be the seed.
REQ-031 The read-side expected generator SHALL be independent of the write side and SHALL produce RATIO consecutive words per consumed read word (unrolled).
REQ-032 first_err_idx SHALL keep its all-ones sentinel when no error occurs.

Reset
REQ-033 On rstn=0, the state SHALL go to IDLE asynchronously, including mid-test.
REQ-034 On rstn=0, wr_en, rd_en, busy, done, pass, timeout, err_count and wr_data SHALL be 0, and first_err_idx SHALL be all-ones.

Verification
REQ-035 Defaults, mode=0, ideal loopback FIFO, wr_ready=1: 256 writes 0x00..0xFF, first read word 0x0100, done=1, pass=1, err_count=0.
REQ-036 mode=2 with bit 3 of read word 5 flipped: err_count=1, first_err_idx=5, pass=0.
REQ-037 wr_ready toggling every cycle, mode=3: 256 writes completed, write sequence 0x01,0x02,...,0x80,0x01, pass=1.
REQ-038 rd_valid held 0 after the writes: timeout=1 exactly TIMEOUT cycles after entering WAIT_RD, done=1, pass=0.
REQ-039 rstn pulsed low at write 100, then start again: outputs at reset values during reset, fresh test with wr_data=0x00, pass=1.
REQ-040 start with calib_done=0 for 50 cycles: wr_en stays 0 and busy=1 during those cycles; a second start pulse is ignored.

Source files
------------

// File: rtl/fifo_bist.sv
// Built-in self test for a width-converting DDR-backed FIFO: writes a pattern,
// reads it back RATIO words at a time, and reports errors and timeouts.
module fifo_bist #(
  parameter int WR_W    = 8,
  parameter int RATIO   = 2,
  parameter int LENGTH  = 256,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 4096,
  localparam int RD_N   = LENGTH / RATIO,
  localparam int IDX_W  = $clog2(RD_N) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    calib_done,
  output logic [WR_W-1:0]         wr_data,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic                    rd_en,
  input  logic [WR_W*RATIO-1:0]   rd_data,
  input  logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_W-1:0]        err_count,
  output logic [IDX_W-1:0]        first_err_idx
);

  localparam int CNT_W = $clog2(LENGTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] SEED = 32'hACE1ACE1;

  typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, WAIT_RD, READ, DONE} state_t;

  // All four pattern sources advance together; mode only selects which one is shown.
  typedef struct packed {
    logic [31:0]     lfsr;
    logic [WR_W-1:0] walk;
    logic [WR_W-1:0] inc;
  } gen_t;

  function automatic gen_t gen_seed();
    gen_t g;
    g.lfsr = SEED;
    g.walk = WR_W'(1);
    g.inc  = '0;
    return g;
  endfunction

  function automatic gen_t gen_step(input gen_t g);
    gen_t n;
    n.lfsr = {g.lfsr[30:0], g.lfsr[31] ^ g.lfsr[21] ^ g.lfsr[1] ^ g.lfsr[0]};
    n.walk = (g.walk << 1) | (g.walk >> (WR_W - 1));
    n.inc  = g.inc + WR_W'(1);
    return n;
  endfunction

  function automatic logic [WR_W-1:0] gen_pat(input logic [1:0] m, input gen_t g);
    logic [WR_W-1:0] w;
    case (m)
      2'd0:    w = g.inc;
      2'd1:    w = ~g.inc;
      2'd2:    w = g.lfsr[WR_W-1:0];
      2'd3:    w = g.walk;
      default: w = g.inc;
    endcase
    return w;
  endfunction

  state_t                state_q;
  logic [1:0]            mode_q;
  gen_t                  wr_gen_q, rd_gen_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic [IDX_W-1:0]      rd_cnt_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  wr_en_q, rd_en_q, busy_q, done_q, pass_q, timeout_q;
  logic [ERR_W-1:0]      err_q;
  logic [IDX_W-1:0]      first_q;
  logic [WR_W-1:0]       wr_data_q;

  gen_t                  wr_gen_d, rd_gen_d;
  logic [WR_W*RATIO-1:0] exp_s;
  logic                  consume_s, mismatch_s;
  logic [ERR_W-1:0]      err_d;

  // Expected read word: RATIO consecutive pattern words, oldest in the LSBs.
  always_comb begin
    rd_gen_d = rd_gen_q;
    exp_s    = '0;
    for (int j = 0; j < RATIO; j++) begin
      exp_s[j*WR_W +: WR_W] = gen_pat(mode_q, rd_gen_d);
      rd_gen_d = gen_step(rd_gen_d);
    end
  end

  assign wr_gen_d   = gen_step(wr_gen_q);
  assign consume_s  = rd_en_q & rd_valid;
  assign mismatch_s = (rd_data != exp_s);
  assign err_d      = (mismatch_s && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;

  // Test sequencer with registered status and channel controls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      mode_q    <= 2'd0;
      wr_gen_q  <= gen_seed();
      rd_gen_q  <= gen_seed();
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '1;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= WAIT_CAL;
            mode_q    <= mode;
            wr_gen_q  <= gen_seed();
            rd_gen_q  <= gen_seed();
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            first_q   <= '1;
            wr_data_q <= gen_pat(mode, gen_seed());
          end
        end
        WAIT_CAL: begin
          if (calib_done) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_en_q && wr_ready) begin
            wr_gen_q  <= wr_gen_d;
            wr_data_q <= gen_pat(mode_q, wr_gen_d);
            wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q == CNT_W'(LENGTH - 1)) begin
              state_q <= WAIT_RD;
              wr_en_q <= 1'b0;
              rd_en_q <= 1'b1;
            end
          end
        end
        WAIT_RD, READ: begin
          if (consume_s) begin
            tmo_q    <= '0;
            rd_gen_q <= rd_gen_d;
            rd_cnt_q <= rd_cnt_q + IDX_W'(1);
            err_q    <= err_d;
            if (mismatch_s && (err_q == '0)) begin
              first_q <= rd_cnt_q;
            end
            if (rd_cnt_q == IDX_W'(RD_N - 1)) begin
              state_q <= DONE;
              rd_en_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              state_q <= READ;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_data       = wr_data_q;
  assign wr_en         = wr_en_q;
  assign rd_en         = rd_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_fifo_bist.sv
// Bench for fifo_bist: loopback FIFO model with fault/stall knobs and a
// scoreboard of expected write words and end-of-test status.
module tb_fifo_bist;

  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        calib_done = 1'b0;
  logic        wr_ready = 1'b1;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic [7:0]  wr_data;
  logic        wr_en, rd_en, busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [7:0]  first_err_idx;

  fifo_bist #(.WR_W(8), .RATIO(2), .LENGTH(256), .ERR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .calib_done(calib_done),
    .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [15:0] err;
    logic [7:0]  first;
  } st_t;

  logic [7:0]  exp_wr[$];
  logic [15:0] exp_rd[$];
  st_t         exp_st[$];
  logic [7:0]  fq[$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_idx = 0;
  int          flip_idx = -1;
  logic [15:0] flip_mask = 16'h0000;
  bit          toggle = 1'b0;
  bit          block = 1'b0;
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Loopback FIFO: captures writes, pops on reads, presents rd_valid/rd_data just after the edge.
  always @(posedge clk) begin
    logic [15:0] w;
    cyc++;
    if (rstn && wr_en && wr_ready) begin
      fq.push_back(wr_data);
      wr_cnt++;
    end
    if (rstn && rd_en && rd_valid) begin
      void'(fq.pop_front());
      void'(fq.pop_front());
      rd_idx++;
    end
    #1;
    wr_ready = toggle ? ~wr_ready : 1'b1;
    rd_valid = !block && (fq.size() >= 2);
    w = 16'h0000;
    if (fq.size() >= 2) w = {fq[1], fq[0]};
    if (rd_idx == flip_idx) w = w ^ flip_mask;
    rd_data = rd_valid ? w : 16'h0000;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    st_t s;
    if (rstn && wr_en && wr_ready) begin
      if (exp_wr.size() == 0) fail_now("wr_unexpected");
      else chk("wr_data", {24'd0, wr_data}, {24'd0, exp_wr.pop_front()});
    end
    if (rstn && rd_en && rd_valid && exp_rd.size() > 0)
      chk("rd_first_word", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
    if (rstn && done && !done_prev) begin
      if (exp_st.size() == 0) fail_now("done_unexpected");
      else begin
        s = exp_st.pop_front();
        chk("pass", {31'd0, pass}, {31'd0, s.pass});
        chk("timeout", {31'd0, timeout}, {31'd0, s.tmo});
        chk("err_count", {16'd0, err_count}, {16'd0, s.err});
        chk("first_err_idx", {24'd0, first_err_idx}, {24'd0, s.first});
        chk("writes_left", exp_wr.size(), 32'd0);
      end
    end
    done_prev = done;
  end

  task automatic check_reset_vals();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_first_err_idx", {24'd0, first_err_idx}, 32'h0000_00FF);
  endtask

  task automatic begin_test(input logic [1:0] m, input bit tog, input int fidx,
                            input logic [15:0] fmask, input bit blk, input bit cal, input st_t s);
    logic [31:0] lf;
    logic [7:0]  v;
    @(negedge clk);
    fq.delete();
    wr_cnt = 0;
    rd_idx = 0;
    toggle = tog;
    flip_idx = fidx;
    flip_mask = fmask;
    block = blk;
    calib_done = cal;
    lf = 32'hACE1ACE1;
    for (int i = 0; i < 256; i++) begin
      case (m)
        2'd0:    v = 8'(i);
        2'd1:    v = 8'(255 - i);
        2'd2:    v = lf[7:0];
        default: v = 8'h01 << (i % 8);
      endcase
      exp_wr.push_back(v);
      lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
    end
    exp_st.push_back(s);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) fail_now(name);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int t0;
    st_t ok_st;
    ok_st = '{1'b1, 1'b0, 16'd0, 8'hFF};

    repeat (3) @(negedge clk);
    check_reset_vals();
    rstn = 1'b1;
    calib_done = 1'b1;

    // Incrementing pattern, ideal loopback.
    exp_rd.push_back(16'h0100);
    begin_test(2'd0, 1'b0, -1, 16'h0000, 1'b0, 1'b1, ok_st);
    wait_done("t1_done_wait");

    // LFSR pattern with bit 3 of read word 5 corrupted.
    begin_test(2'd2, 1'b0, 5, 16'h0008, 1'b0, 1'b1, '{1'b0, 1'b0, 16'd1, 8'd5});
    wait_done("t2_done_wait");

    // Walking ones with write backpressure every other cycle.
    begin_test(2'd3, 1'b1, -1, 16'h0000, 1'b0, 1'b1, ok_st);
    wait_done("t3_done_wait");
    toggle = 1'b0;

    // Read side never becomes valid.
    begin_test(2'd0, 1'b0, -1, 16'h0000, 1'b1, 1'b1, '{1'b0, 1'b1, 16'd0, 8'hFF});
    n = 0;
    while (wr_cnt < 256 && n < 5000) begin @(negedge clk); n++; end
    if (wr_cnt < 256) fail_now("t4_write_wait");
    t0 = cyc;
    n = 0;
    while (timeout !== 1'b1 && n < 2 * TIMEOUT) begin @(negedge clk); n++; end
    chk("timeout_latency", cyc - t0, TIMEOUT);
    chk("timeout_done", {31'd0, done}, 32'd1);
    wait_done("t4_done_wait");
    block = 1'b0;

    // Reset in the middle of the write phase, then a fresh run.
    begin_test(2'd0, 1'b0, -1, 16'h0000, 1'b0, 1'b1, ok_st);
    n = 0;
    while (wr_cnt < 100 && n < 5000) begin @(negedge clk); n++; end
    if (wr_cnt < 100) fail_now("t5_write_wait");
    #2;
    rstn = 1'b0;
    @(negedge clk);
    check_reset_vals();
    exp_wr.delete();
    exp_st.delete();
    fq.delete();
    @(negedge clk);
    rstn = 1'b1;
    begin_test(2'd0, 1'b0, -1, 16'h0000, 1'b0, 1'b1, ok_st);
    wait_done("t5_done_wait");

    // Calibration held off for 50 cycles; a second start meanwhile must be ignored.
    begin_test(2'd1, 1'b0, -1, 16'h0000, 1'b0, 1'b0, ok_st);
    for (int i = 0; i < 50; i++) begin
      chk("calib_hold_wr_en_busy", {30'd0, wr_en, busy}, 32'd1);
      if (i == 25) begin
        mode = 2'd0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    calib_done = 1'b1;
    wait_done("t6_done_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
